codec_cfg_seq: RTL and testbench

//  Sequences audio-codec register writes over the shared I2C write engine. After reset it walks
//  the full init table; each Go pulse from the mic-bias toggle logic then rewrites only the

---
 rtl/codec_cfg_seq_pkg.sv | 47 ++++
 rtl/codec_cfg_seq_if.sv | 26 ++
 rtl/codec_cfg_seq_rom.sv | 30 +++
 rtl/codec_cfg_seq.sv | 171 +++++++++++++++++
 tb/tb_codec_cfg_seq.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/codec_cfg_seq_pkg.sv
// Shared definitions for the codec configuration sequencer: codec register addresses,
// FSM state and mode encodings, MICPD bit position and the I2C word layout helper.
package codec_cfg_seq_pkg;

  // I2C word layout: {reg_addr[6:0], reg_data[8:0]}
  localparam int unsigned AddrW = 7;
  localparam int unsigned DataW = 9;
  localparam int unsigned WordW = AddrW + DataW;

  // Codec register addresses
  localparam logic [AddrW-1:0] RegLeftLineIn  = 7'h00;
  localparam logic [AddrW-1:0] RegRightLineIn = 7'h01;
  localparam logic [AddrW-1:0] RegLeftHpOut   = 7'h02;
  localparam logic [AddrW-1:0] RegRightHpOut  = 7'h03;
  localparam logic [AddrW-1:0] RegAnalogPath  = 7'h04;
  localparam logic [AddrW-1:0] RegDigitalPath = 7'h05;
  localparam logic [AddrW-1:0] RegPowerDown   = 7'h06;
  localparam logic [AddrW-1:0] RegDigIfFormat = 7'h07;
  localparam logic [AddrW-1:0] RegSampling    = 7'h08;
  localparam logic [AddrW-1:0] RegActive      = 7'h09;
  localparam logic [AddrW-1:0] RegReset       = 7'h0F;

  // MICPD bit inside the power-down register data field
  localparam int unsigned MicpdBit = 1;

  typedef enum logic [2:0] {
    StIdle,
    StInitLoad,
    StR6Load,
    StStart,
    StWait,
    StGap,
    StNext,
    StFail
  } state_e;

  typedef enum logic {
    ModeInit,
    ModeR6
  } mode_e;

  function automatic logic [WordW-1:0] i2c_word(input logic [AddrW-1:0] addr,
                                                 input logic [DataW-1:0] data);
    return {addr, data};
  endfunction

endpackage

// File: rtl/codec_cfg_seq_if.sv
// Handshake bundle between the configuration sequencer (master) and the shared I2C
// write engine (slave).
//   i2c_Go      master->slave  1-cycle start pulse
//   i2c_Data    master->slave  {reg_addr[6:0], reg_data[8:0]}, stable while the transfer runs
//   i2c_Done    slave->master  1-cycle pulse, transfer finished
//   i2c_Ack_err slave->master  valid with i2c_Done, 1 = NACK
interface codec_cfg_seq_if;
  logic        i2c_Go;
  logic [15:0] i2c_Data;
  logic        i2c_Done;
  logic        i2c_Ack_err;

  modport master (
    output i2c_Go,
    output i2c_Data,
    input  i2c_Done,
    input  i2c_Ack_err
  );

  modport slave (
    input  i2c_Go,
    input  i2c_Data,
    output i2c_Done,
    output i2c_Ack_err
  );
endinterface

// File: rtl/codec_cfg_seq_rom.sv
// Codec init table: combinational index -> 16-bit I2C word.
//   idx_i   in   4   table index 0..9 (others return 0)
//   word_o  out  16  {reg_addr, reg_data}
// Entry n writes codec register Rn: line-in levels, headphone levels, analog path with mic
// boost and mic input selected, digital path, power-down, I2S 16-bit format, sampling, active.
module codec_cfg_seq_rom
  import codec_cfg_seq_pkg::*;
(
  input  logic [3:0]       idx_i,
  output logic [WordW-1:0] word_o
);

  always_comb begin
    word_o = '0;
    case (idx_i)
      4'd0:    word_o = i2c_word(RegLeftLineIn,  9'h017);  // 0 dB, unmuted
      4'd1:    word_o = i2c_word(RegRightLineIn, 9'h017);
      4'd2:    word_o = i2c_word(RegLeftHpOut,   9'h079);  // 0 dB
      4'd3:    word_o = i2c_word(RegRightHpOut,  9'h079);
      4'd4:    word_o = i2c_word(RegAnalogPath,  9'h015);  // MICBOOST, INSEL=mic, DACSEL
      4'd5:    word_o = i2c_word(RegDigitalPath, 9'h000);
      4'd6:    word_o = i2c_word(RegPowerDown,   9'h000);  // all blocks powered
      4'd7:    word_o = i2c_word(RegDigIfFormat, 9'h002);  // I2S, 16-bit
      4'd8:    word_o = i2c_word(RegSampling,    9'h000);  // normal mode, 48 kHz
      4'd9:    word_o = i2c_word(RegActive,      9'h001);
      default: word_o = '0;
    endcase
  end

endmodule

// File: rtl/codec_cfg_seq.sv
// Audio-codec configuration sequencer. After reset walks the whole init table over the
// shared I2C write engine; afterwards each Go rewrites only the power-down register with
// MICPD = ~MICB_Power. All requests are serialised so the engine sees a single master.
//   Clk         in   1  system clock
//   Rst_n       in   1  asynchronous active-low reset
//   Go          in   1  1-cycle request to rewrite R6
//   MICB_Power  in   1  1 = mic bias on (MICPD = 0)
//   i2c         master modport of codec_cfg_seq_if (Go/Data out, Done/Ack_err in)
//   Busy        out  1  a sequence is in progress
//   Cfg_Done    out  1  1-cycle pulse when a sequence completes
//   Err         out  1  sticky retry-exhaustion flag, cleared when the next sequence starts
module codec_cfg_seq
  import codec_cfg_seq_pkg::*;
#(
  parameter int unsigned NUM_REGS   = 10,
  parameter int unsigned PD_INDEX   = 6,
  parameter logic [15:0] GAP_CYCLES = 16'd5000,
  parameter int unsigned RETRY_MAX  = 2
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic                   Go,
  input  logic                   MICB_Power,
  codec_cfg_seq_if.master        i2c,
  output logic                   Busy,
  output logic                   Cfg_Done,
  output logic                   Err
);

  localparam logic [3:0] LastIdx  = 4'(NUM_REGS - 1);
  localparam logic [3:0] PdIdx    = 4'(PD_INDEX);
  localparam logic [1:0] RetryMax = 2'(RETRY_MAX);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [3:0]       idx_q, idx_d;
  logic [1:0]       retry_q, retry_d;
  logic             pend_q, pend_d;
  logic [15:0]      gap_q, gap_d;
  logic [WordW-1:0] data_q, data_d;
  logic             err_q, err_d;

  logic [3:0]       rom_idx;
  logic [WordW-1:0] rom_word;
  logic [WordW-1:0] r6_word;
  logic             i2c_go;
  logic             cfg_done;

  // One ROM serves both the init walk and the R6 rewrite.
  assign rom_idx = (state_q == StR6Load) ? PdIdx : idx_q;

  codec_cfg_seq_rom u_rom (
    .idx_i  (rom_idx),
    .word_o (rom_word)
  );

  always_comb begin
    r6_word           = rom_word;
    r6_word[MicpdBit] = ~MICB_Power;
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    idx_d    = idx_q;
    retry_d  = retry_q;
    pend_d   = pend_q;
    gap_d    = gap_q;
    data_d   = data_q;
    err_d    = err_q;
    i2c_go   = 1'b0;
    cfg_done = 1'b0;

    // Requests arriving while busy collapse into one pending R6 update, serviced from
    // idle with MICB_Power as it is at service time.
    if (Go && (state_q != StIdle)) begin
      pend_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (pend_q || Go) begin
          pend_d  = 1'b0;
          err_d   = 1'b0;
          state_d = StR6Load;
        end
      end
      StInitLoad: begin
        data_d  = rom_word;
        retry_d = '0;
        mode_d  = ModeInit;
        state_d = StStart;
      end
      StR6Load: begin
        data_d  = r6_word;
        retry_d = '0;
        mode_d  = ModeR6;
        state_d = StStart;
      end
      StStart: begin
        i2c_go  = 1'b1;
        state_d = StWait;
      end
      StWait: begin
        if (i2c.i2c_Done) begin
          gap_d = '0;
          if (!i2c.i2c_Ack_err) begin
            retry_d = '0;
            state_d = StGap;
          end else if (retry_q < RetryMax) begin
            retry_d = retry_q + 2'd1;
            state_d = StGap;
          end else begin
            state_d = StFail;
          end
        end
      end
      StGap: begin
        // Nonzero retry count means the last attempt was NACKed: reissue the same word.
        if (gap_q >= GAP_CYCLES - 16'd1) begin
          state_d = (retry_q != '0) ? StStart : StNext;
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end
      StNext: begin
        if ((mode_q == ModeR6) || (idx_q == LastIdx)) begin
          cfg_done = 1'b1;
          state_d  = StIdle;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = StInitLoad;
        end
      end
      StFail: begin
        err_d   = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= StInitLoad;
      mode_q  <= ModeInit;
      idx_q   <= '0;
      retry_q <= '0;
      pend_q  <= 1'b0;
      gap_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      retry_q <= retry_d;
      pend_q  <= pend_d;
      gap_q   <= gap_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign i2c.i2c_Go   = i2c_go;
  assign i2c.i2c_Data = data_q;
  assign Busy         = (state_q != StIdle);
  assign Cfg_Done     = cfg_done;
  assign Err          = err_q;

endmodule

// File: tb/tb_codec_cfg_seq.sv
module tb_codec_cfg_seq;

  localparam logic [15:0] Gap      = 16'd20;
  localparam int          RetryMax = 2;
  localparam int          Budget   = 20000;

  logic clk = 1'b0;
  logic rst_n;
  logic go;
  logic micb;
  logic busy, cfg_done, err;

  codec_cfg_seq_if bus ();

  codec_cfg_seq #(
    .NUM_REGS   (10),
    .PD_INDEX   (6),
    .GAP_CYCLES (Gap),
    .RETRY_MAX  (RetryMax)
  ) dut (
    .Clk        (clk),
    .Rst_n      (rst_n),
    .Go         (go),
    .MICB_Power (micb),
    .i2c        (bus),
    .Busy       (busy),
    .Cfg_Done   (cfg_done),
    .Err        (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_q[$];
  logic        ack_plan[$];
  int          go_cnt = 0;
  int          done_cnt = 0;
  int          last_done = -100000;
  int          spur_req = 0;

  // Reference codec register contents, indexed by register number.
  function automatic int init_data(input int i);
    case (i)
      0, 1:    return 'h017;
      2, 3:    return 'h079;
      4:       return 'h015;
      7:       return 'h002;
      9:       return 'h001;
      default: return 'h000;
    endcase
  endfunction

  function automatic logic [15:0] init_word(input int i);
    return 16'(i * 512 + init_data(i));
  endfunction

  // R6 with MICPD (bit 1) = ~mic bias power
  function automatic logic [15:0] r6_word(input logic m);
    int d;
    d = init_data(6) - (init_data(6) & 2) + (m ? 0 : 2);
    return 16'(6 * 512 + d);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  // Monitor: pops the expected word on every i2c_Go and checks the inter-write gap.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (bus.i2c_Go === 1'b1) begin
          go_cnt++;
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_write: got data %0h, expected no write", bus.i2c_Data);
          end else begin
            check("i2c_data", 32'(bus.i2c_Data), 32'(exp_q.pop_front()));
          end
          check("gap_cycles", ((cyc - last_done) > int'(Gap)) ? 1 : 0, 1);
        end
        if (cfg_done === 1'b1) done_cnt++;
      end
    end
  end

  // I2C engine model: Done 2..6 cycles after Go, NACK/ACK taken from ack_plan.
  initial begin
    int cnt;
    int spur_seen;
    cnt = 0;
    spur_seen = 0;
    bus.i2c_Done = 1'b0;
    bus.i2c_Ack_err = 1'b0;
    forever begin
      @(negedge clk);
      bus.i2c_Done = 1'b0;
      bus.i2c_Ack_err = 1'b0;
      if (rst_n !== 1'b1) begin
        cnt = 0;
        last_done = -100000;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            bus.i2c_Done = 1'b1;
            bus.i2c_Ack_err = (ack_plan.size() > 0) ? ack_plan.pop_front() : 1'b0;
            last_done = cyc;
          end
        end else if (spur_req != spur_seen) begin
          spur_seen++;
          bus.i2c_Done = 1'b1;
        end
        if (bus.i2c_Go === 1'b1) cnt = int'($urandom_range(2, 6));
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    go = 1'b0;
    repeat (3) @(negedge clk);
    exp_q.delete();
    ack_plan.delete();
  endtask

  task automatic push_init();
    for (int i = 0; i < 10; i++) exp_q.push_back(init_word(i));
  endtask

  task automatic pulse_go();
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_done(input int target, input string name);
    int n;
    n = 0;
    while ((done_cnt < target || busy !== 1'b0) && n < Budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= Budget) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: got busy=%0b done=%0d, expected idle done=%0d",
               name, busy, done_cnt, target);
    end
    check({name, "_cfg_done"}, done_cnt, target);
    check({name, "_err"}, err, 0);
    check({name, "_queue"}, exp_q.size(), 0);
  endtask

  task automatic run_nack(input int w, input int n);
    int base;
    int att;
    int t;
    base = done_cnt;
    micb = 1'($urandom);
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (i == w) begin
        att = (n > RetryMax) ? RetryMax + 1 : n + 1;
        for (int k = 0; k < att; k++) begin
          exp_q.push_back(init_word(i));
          ack_plan.push_back(k < n);
        end
        if (n > RetryMax) break;
      end else begin
        exp_q.push_back(init_word(i));
        if (i < w) ack_plan.push_back(1'b0);
      end
    end
    rst_n = 1'b1;
    if (n > RetryMax) begin
      t = 0;
      while (err !== 1'b1 && t < Budget) begin
        @(negedge clk);
        t++;
      end
      check("fail_err_set", err, 1);
      check("fail_busy", busy, 0);
      repeat (3 * int'(Gap)) @(negedge clk);
      check("fail_no_cfg_done", done_cnt, base);
      check("fail_words_left", exp_q.size(), 0);
      micb = 1'($urandom);
      exp_q.push_back(r6_word(micb));
      pulse_go();
      check("go_clears_err", err, 0);
      wait_done(base + 1, "after_fail");
    end else begin
      wait_done(base + 1, "nack_retry");
    end
  endtask

  initial begin
    int base;
    int t;
    rst_n = 1'b0;
    go = 1'b0;
    micb = 1'b0;

    // Reset values
    do_reset();
    check("rst_busy", busy, 1);
    check("rst_i2c_go", bus.i2c_Go, 0);
    check("rst_i2c_data", bus.i2c_Data, 0);
    check("rst_cfg_done", cfg_done, 0);
    check("rst_err", err, 0);

    // Full init, always ACK
    micb = 1'($urandom);
    push_init();
    rst_n = 1'b1;
    wait_done(1, "init");

    // R6 updates from idle, both polarities then random
    for (int i = 0; i < 6; i++) begin
      base = done_cnt;
      micb = (i == 0) ? 1'b1 : (i == 1) ? 1'b0 : 1'($urandom);
      repeat (int'($urandom_range(1, 10))) @(negedge clk);
      exp_q.push_back(r6_word(micb));
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      check("latency_early", bus.i2c_Go, 0);
      @(negedge clk);
      check("latency_go", bus.i2c_Go, 1);
      wait_done(base + 1, "r6_update");
    end

    // Done outside WAIT must be ignored
    spur_req++;
    repeat (10) @(negedge clk);
    check("spurious_done_busy", busy, 0);

    // Several Go pulses during init collapse to one R6 write with final MICB_Power
    base = done_cnt;
    do_reset();
    push_init();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      repeat (int'($urandom_range(10, 60))) @(negedge clk);
      micb = 1'($urandom);
      pulse_go();
    end
    check("go_during_init_busy", busy, 1);
    micb = 1'($urandom);
    exp_q.push_back(r6_word(micb));
    wait_done(base + 2, "pend_collapse");

    // NACK handling: fixed cases then random ones
    run_nack(4, 2);
    run_nack(2, 3);
    for (int i = 0; i < 3; i++) run_nack(int'($urandom_range(0, 9)), int'($urandom_range(0, 3)));

    // Reset during WAIT of word 5 restarts the walk from word 0
    base = done_cnt;
    do_reset();
    push_init();
    rst_n = 1'b1;
    t = go_cnt;
    while (go_cnt < t + 6 && (go_cnt - t) < 100000 && cyc < 90000) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_busy", busy, 1);
    check("midrst_i2c_go", bus.i2c_Go, 0);
    check("midrst_i2c_data", bus.i2c_Data, 0);
    check("midrst_cfg_done", cfg_done, 0);
    check("midrst_err", err, 0);
    check("midrst_words_seen", go_cnt - t, 6);
    exp_q.delete();
    ack_plan.delete();
    push_init();
    rst_n = 1'b1;
    wait_done(base + 1, "restart_init");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
